axi_sram_bridge_mo: RTL
=======================

Name: axi_sram_bridge_mo

Overview:
Parametrised successor to the single-outstanding SRAM-like-to-AXI bridge. It connects the CPU's inst and data SRAM-like ports to one AXI3 master, with a configurable number of outstanding reads per port and outstanding writes on the data port. Responses return in order per port, data-port read/write ordering is enforced, and address-channel arbitration is fixed. It sits between the CPU core and the AXI crossbar/RAM.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (wstrb = DATA_W/8)
MAX_RD, 4, max outstanding reads per port (1..8)
MAX_WR, 2, max outstanding writes, data port (1..8)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
inst_sram_req  in  1  inst read request (read-only port)
inst_sram_size  in  2  0:1B 1:2B 2:4B
inst_sram_addr  in  ADDR_W  request address
inst_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok  out  1  read data valid this cycle
inst_sram_rdata  out  DATA_W  read data
data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/DATA_W/8/ADDR_W/DATA_W  data request fields
data_sram_addr_ok/data_ok  out  1/1  accept / response
data_sram_rdata  out  DATA_W  read data
arid/araddr/arsize/arvalid  out  4/ADDR_W/3/1  AR channel
arready  in  1  AR ready
arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3  constants 0/01/0/0/0
rid/rdata/rresp/rlast/rvalid  in  4/DATA_W/2/1/1  R channel (rresp, rlast ignored)
rready  out  1  R ready
awid/awaddr/awsize/awvalid  out  4/ADDR_W/3/1  AW channel, awid=1
awready  in  1  AW ready
awlen/awburst/awlock/awcache/awprot  out  8/2/2/4/3  constants 0/01/0/0/0
wid/wdata/wstrb/wlast/wvalid  out  4/DATA_W/DATA_W/8/1/1  W channel, wid=1, wlast=1
wready  in  1  W ready
bid/bresp/bvalid  in  4/2/1  B channel (bid, bresp ignored)
bready  out  1  B ready

Behaviour:
- Reset (async): all valids, addr_ok, data_ok, counters and slots are 0; all address/data/rdata regs are 0; rready and bready are 0 during reset and 1 otherwise. Reset mid-transaction abandons everything.
- AR slot: one-entry register. Free when arvalid=0, or arvalid&arready this cycle.
- Read accept (addr_ok, combinational): AR slot free, port read count < MAX_RD, and for the data port wr_cnt==0.
- If both ports qualify, the data port wins and inst waits.
- On accept, next cycle arvalid=1 with arid = 0 (inst) or 1 (data), araddr = addr, arsize = {1'b0,size}. Fields are held until arready.
- Back-to-back accepts every cycle are allowed when arready=1.
- R: rid[0] selects the port. rdata is registered into that port's rdata, with data_ok pulsed 1 cycle after the r handshake. Order within a port is AXI in-order per ID.
- Read counter (per port): +1 on accept, −1 on data_ok; simultaneous → unchanged. At count==MAX_RD, addr_ok is held low.
- Write accept (data port): AW/W slot free (neither awvalid nor wvalid pending), wr_cnt < MAX_WR, data rd_cnt==0.
- On write accept, awvalid and wvalid both rise the next cycle. Each drops independently on its own handshake, and the slot is free once both have completed. awsize = {1'b0,size}; wstrb and wdata are passed unchanged.
- B: bvalid&bready → data_sram_data_ok 1 cycle later; wr_cnt −1 (+1 on accept, simultaneous unchanged).
- Data-port ordering:
  - A read is not accepted while writes are outstanding, and vice versa. This also removes the read-after-write address hazard.
  - A read data_ok and a B data_ok therefore never coincide.
- Same-cycle R beat for inst and B for data: both data_ok pulses are issued; they go to independent ports.
- req with addr_ok low: the requester holds its fields; the bridge samples nothing.

Decomposition:
- Package axi_bridge_pkg:
  - ID_INST=0, ID_DATA=1
  - BURST_INCR=2'b01
  - width macros A_ID_WID, A_LEN_WID, A_SIZE_WID, A_STRB_WID, A_RESP_WID
  - size→axsize function
- Sub-module axi_req_slot: a parametrised one-entry valid/ready holding register. It is instanced for AR, AW and W.
- Outstanding counters stay inline.

Test Plan:
- Inst read 0x1C000000, arready=1, rvalid 3 cycles later with 0xDEADBEEF → addr_ok same cycle, arvalid next cycle with arid=0, arsize=2, inst data_ok/rdata=0xDEADBEEF 1 cycle after r handshake.
- MAX_RD=4, 5 inst reads back-to-back, slave withholds R → 4 accepted, 5th addr_ok stays 0 until first R beat returns, then accepted.
- Inst and data read requests in the same cycle → data accepted first (arid=1), inst next cycle; responses returned interleaved R(1),R(0) are routed to the correct ports.
- Data write 0x100, wstrb=4'b0011, size=1 with awready delayed 3 cycles and wready=1 → wvalid drops after 1 cycle, awvalid held until handshake, awsize=1, data_ok 1 cycle after bvalid.
- Data write outstanding, then data read of same address → read addr_ok=0 until B received, then accepted; wr_cnt returns to 0.
- Assert aresetn low mid-read with arvalid=1 → arvalid, counters and data_ok go 0 immediately; after release a new read completes normally.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// Shared AXI3 channel widths, fixed IDs and helpers for the SRAM-like to AXI bridge.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axi_bridge_pkg;

  localparam int A_ID_WID    = 4;
  localparam int A_LEN_WID   = 8;
  localparam int A_SIZE_WID  = 3;
  localparam int A_STRB_WID  = 4;  // strobe width for the default 32-bit data bus
  localparam int A_RESP_WID  = 2;
  localparam int A_BURST_WID = 2;
  localparam int A_LOCK_WID  = 2;
  localparam int A_CACHE_WID = 4;
  localparam int A_PROT_WID  = 3;

  localparam logic [A_ID_WID-1:0]    ID_INST    = 4'd0;
  localparam logic [A_ID_WID-1:0]    ID_DATA    = 4'd1;
  localparam logic [A_BURST_WID-1:0] BURST_INCR = 2'b01;

  // SRAM-like size code (0:1B 1:2B 2:4B) maps directly onto AXI axsize.
  function automatic logic [A_SIZE_WID-1:0] size_to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_req_slot.sv
// One-entry valid/ready holding register for an AXI address or write-data channel.
// Latency: a load appears on vld/dat the following cycle.
// Backpressure: vld/dat held until rdy; free is high when empty or completing, so loads may overlap a handshake.
// Ports: clk/rst_n; load/load_dat capture a request; rdy is the channel ready;
//        vld/dat drive the channel; free tells the requester a load is allowed this cycle.
module axi_req_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         rdy,
  output logic         vld,
  output logic [W-1:0] dat,
  output logic         free
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q && !rdy;
    dat_d = dat_q;
    if (load) begin
      vld_d = 1'b1;
      dat_d = load_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld  = vld_q;
  assign dat  = dat_q;
  assign free = !vld_q || rdy;

endmodule

// File: rtl/axi_sram_bridge_mo.sv
// Bridges CPU inst/data SRAM-like ports onto one AXI3 master with multiple outstanding transactions.
// Latency: addr_ok combinational; AR/AW/W valid next cycle; data_ok one cycle after the R/B handshake.
// Backpressure: addr_ok held low when the channel slot is busy, a counter is full, or data-port rd/wr ordering blocks.
// Ports: inst_sram_* (read-only), data_sram_* (read/write), AXI3 AR/R/AW/W/B master channels.
module axi_sram_bridge_mo
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_RD = 4,
  parameter int MAX_WR = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   inst_sram_req,
  input  logic [1:0]             inst_sram_size,
  input  logic [ADDR_W-1:0]      inst_sram_addr,
  output logic                   inst_sram_addr_ok,
  output logic                   inst_sram_data_ok,
  output logic [DATA_W-1:0]      inst_sram_rdata,
  input  logic                   data_sram_req,
  input  logic                   data_sram_wr,
  input  logic [1:0]             data_sram_size,
  input  logic [DATA_W/8-1:0]    data_sram_wstrb,
  input  logic [ADDR_W-1:0]      data_sram_addr,
  input  logic [DATA_W-1:0]      data_sram_wdata,
  output logic                   data_sram_addr_ok,
  output logic                   data_sram_data_ok,
  output logic [DATA_W-1:0]      data_sram_rdata,
  output logic [A_ID_WID-1:0]    arid,
  output logic [ADDR_W-1:0]      araddr,
  output logic [A_LEN_WID-1:0]   arlen,
  output logic [A_SIZE_WID-1:0]  arsize,
  output logic [A_BURST_WID-1:0] arburst,
  output logic [A_LOCK_WID-1:0]  arlock,
  output logic [A_CACHE_WID-1:0] arcache,
  output logic [A_PROT_WID-1:0]  arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [A_ID_WID-1:0]    rid,
  input  logic [DATA_W-1:0]      rdata,
  input  logic [A_RESP_WID-1:0]  rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [A_ID_WID-1:0]    awid,
  output logic [ADDR_W-1:0]      awaddr,
  output logic [A_LEN_WID-1:0]   awlen,
  output logic [A_SIZE_WID-1:0]  awsize,
  output logic [A_BURST_WID-1:0] awburst,
  output logic [A_LOCK_WID-1:0]  awlock,
  output logic [A_CACHE_WID-1:0] awcache,
  output logic [A_PROT_WID-1:0]  awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [A_ID_WID-1:0]    wid,
  output logic [DATA_W-1:0]      wdata,
  output logic [DATA_W/8-1:0]    wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [A_ID_WID-1:0]    bid,
  input  logic [A_RESP_WID-1:0]  bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int RC_W   = $clog2(MAX_RD + 1);
  localparam int WC_W   = $clog2(MAX_WR + 1);

  typedef struct packed {
    logic              is_data;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
  } ar_req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
  } aw_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } w_req_t;

  // run_q is low in reset and rises on the first edge after release; it
  // gates all accepts and drives rready/bready.
  logic              run_q, run_d;
  logic [RC_W-1:0]   inst_rd_cnt_q, inst_rd_cnt_d;
  logic [RC_W-1:0]   data_rd_cnt_q, data_rd_cnt_d;
  logic [WC_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic              inst_ok_q, inst_ok_d;
  logic              data_rd_ok_q, data_rd_ok_d;
  logic              b_ok_q, b_ok_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic    ar_free, aw_free, w_free;
  logic    inst_acc, data_rd_acc, data_wr_acc;
  logic    r_hs, r_is_data, b_hs;
  ar_req_t ar_in, ar_out;
  aw_req_t aw_in, aw_out;
  w_req_t  w_in, w_out;

  always_comb begin
    // Data port wins the AR slot; a data write never competes with inst.
    data_rd_acc = run_q && data_sram_req && !data_sram_wr && ar_free &&
                  (data_rd_cnt_q < RC_W'(MAX_RD)) && (wr_cnt_q == '0);
    data_wr_acc = run_q && data_sram_req && data_sram_wr && aw_free && w_free &&
                  (wr_cnt_q < WC_W'(MAX_WR)) && (data_rd_cnt_q == '0);
    inst_acc    = run_q && inst_sram_req && ar_free && !data_rd_acc &&
                  (inst_rd_cnt_q < RC_W'(MAX_RD));

    ar_in.is_data = data_rd_acc;
    ar_in.addr    = data_rd_acc ? data_sram_addr : inst_sram_addr;
    ar_in.size    = data_rd_acc ? data_sram_size : inst_sram_size;
    aw_in.addr    = data_sram_addr;
    aw_in.size    = data_sram_size;
    w_in.data     = data_sram_wdata;
    w_in.strb     = data_sram_wstrb;

    r_hs      = run_q && rvalid;
    r_is_data = (rid[0] == ID_DATA[0]);
    b_hs      = run_q && bvalid;

    run_d        = 1'b1;
    inst_ok_d    = r_hs && !r_is_data;
    data_rd_ok_d = r_hs && r_is_data;
    b_ok_d       = b_hs;
    inst_rdata_d = (r_hs && !r_is_data) ? rdata : inst_rdata_q;
    data_rdata_d = (r_hs && r_is_data)  ? rdata : data_rdata_q;

    // Counters retire with the data_ok pulse, so a full port reopens the cycle after it.
    inst_rd_cnt_d = inst_rd_cnt_q + RC_W'(inst_acc)    - RC_W'(inst_ok_q);
    data_rd_cnt_d = data_rd_cnt_q + RC_W'(data_rd_acc) - RC_W'(data_rd_ok_q);
    wr_cnt_d      = wr_cnt_q      + WC_W'(data_wr_acc) - WC_W'(b_ok_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q         <= 1'b0;
      inst_rd_cnt_q <= '0;
      data_rd_cnt_q <= '0;
      wr_cnt_q      <= '0;
      inst_ok_q     <= 1'b0;
      data_rd_ok_q  <= 1'b0;
      b_ok_q        <= 1'b0;
      inst_rdata_q  <= '0;
      data_rdata_q  <= '0;
    end else begin
      run_q         <= run_d;
      inst_rd_cnt_q <= inst_rd_cnt_d;
      data_rd_cnt_q <= data_rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      inst_ok_q     <= inst_ok_d;
      data_rd_ok_q  <= data_rd_ok_d;
      b_ok_q        <= b_ok_d;
      inst_rdata_q  <= inst_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  axi_req_slot #(.W($bits(ar_req_t))) u_ar_slot (
    .clk(aclk), .rst_n(aresetn), .load(inst_acc || data_rd_acc), .load_dat(ar_in),
    .rdy(arready), .vld(arvalid), .dat(ar_out), .free(ar_free)
  );

  axi_req_slot #(.W($bits(aw_req_t))) u_aw_slot (
    .clk(aclk), .rst_n(aresetn), .load(data_wr_acc), .load_dat(aw_in),
    .rdy(awready), .vld(awvalid), .dat(aw_out), .free(aw_free)
  );

  axi_req_slot #(.W($bits(w_req_t))) u_w_slot (
    .clk(aclk), .rst_n(aresetn), .load(data_wr_acc), .load_dat(w_in),
    .rdy(wready), .vld(wvalid), .dat(w_out), .free(w_free)
  );

  assign inst_sram_addr_ok = inst_acc;
  assign inst_sram_data_ok = inst_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
  // Rd/wr mutual exclusion on the data port keeps these two pulses apart.
  assign data_sram_data_ok = data_rd_ok_q || b_ok_q;
  assign data_sram_rdata   = data_rdata_q;

  assign arid    = ar_out.is_data ? ID_DATA : ID_INST;
  assign araddr  = ar_out.addr;
  assign arsize  = size_to_axsize(ar_out.size);
  assign arlen   = '0;
  assign arburst = BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign rready  = run_q;

  assign awid    = ID_DATA;
  assign awaddr  = aw_out.addr;
  assign awsize  = size_to_axsize(aw_out.size);
  assign awlen   = '0;
  assign awburst = BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

  assign wid     = ID_DATA;
  assign wdata   = w_out.data;
  assign wstrb   = w_out.strb;
  assign wlast   = 1'b1;
  assign bready  = run_q;

  // Single-beat, per-port in-order traffic: only rid[0] routes a beat.
  logic unused_inputs;
  assign unused_inputs = ^{rid[A_ID_WID-1:1], rresp, rlast, bid, bresp};

endmodule
